// File: rtl/acumulador_16bits.sv
// acumulador_16bits: accumulator stage that feeds an external 16-bit adder and folds each operand into a running total
//   clk, rst_n             clock, asynchronous active-low reset
//   clear                  synchronous clear (zeroes sequence state, returns to ACC)
//   in_valid/in_ready      operand handshake; in_data operand, in_op 1=add 0=sub, in_last ends sequence
//   add_a/add_b/add_ctrl   operands and control driven to the external adder
//   add_result/add_ovf     adder result and carry/borrow
//   out_valid/out_ready    result handshake; out_acc total, out_ovf sticky overflow, out_count operands (saturating)
module acumulador_16bits #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_op,
    input  logic             in_last,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    output logic             add_ctrl,
    input  logic [15:0]      add_result,
    input  logic             add_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_acc,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);
    localparam logic ACC  = 1'b0;
    localparam logic HOLD = 1'b1;
    logic             state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, flush;
    assign in_ready  = state_q == ACC;
    assign out_valid = state_q == HOLD;
    assign add_a     = acc_q;
    assign add_b     = in_data;
    assign add_ctrl  = in_op;
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = cnt_q;
    // clear and a completed output handshake both wipe the sequence; clear also beats any accept
    always_comb begin
        accept  = in_valid && in_ready;
        flush   = clear || (out_valid && out_ready);
        state_d = clear ? ACC : out_valid ? (out_ready ? ACC : HOLD) : (accept && in_last ? HOLD : ACC);
        acc_d   = flush ? '0 : accept ? add_result : acc_q;
        ovf_d   = flush ? 1'b0 : accept ? (ovf_q | add_ovf) : ovf_q;
        cnt_d   = flush ? '0 : (accept && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_acumulador_16bits.sv
// tb_acumulador_16bits: self-checking bench with a behavioural adder and a result scoreboard
module tb_acumulador_16bits;
    typedef struct {
        logic [15:0] acc;
        logic        ovf;
        int          cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, in_op, in_last, out_ready;
    logic [15:0] in_data;
    logic        in_ready, add_ctrl, add_ovf, out_valid, out_ovf;
    logic [15:0] add_a, add_b, add_result, out_acc;
    logic [7:0]  out_count;
    logic        s_in_ready, s_add_ctrl, s_add_ovf, s_out_valid, s_out_ovf;
    logic [15:0] s_add_a, s_add_b, s_add_result, s_out_acc;
    logic [1:0]  s_out_count;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [15:0] m_acc = '0;
    logic        m_ovf = 1'b0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    assign {add_ovf, add_result}     = add_ctrl ? {1'b0, add_a} + {1'b0, add_b} : {1'b0, add_a} - {1'b0, add_b};
    assign {s_add_ovf, s_add_result} = s_add_ctrl ? {1'b0, s_add_a} + {1'b0, s_add_b} : {1'b0, s_add_a} - {1'b0, s_add_b};

    acumulador_16bits #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op), .in_last(in_last), .add_a(add_a), .add_b(add_b),
        .add_ctrl(add_ctrl), .add_result(add_result), .add_ovf(add_ovf), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf), .out_count(out_count)
    );

    acumulador_16bits #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_op(in_op), .in_last(in_last), .add_a(s_add_a), .add_b(s_add_b),
        .add_ctrl(s_add_ctrl), .add_result(s_add_result), .add_ovf(s_add_ovf), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_acc(s_out_acc), .out_ovf(s_out_ovf), .out_count(s_out_count)
    );

    function automatic int sat(input int c, input int m);
        return c > m ? m : c;
    endfunction

    task automatic send(input logic [15:0] d, input logic op, input logic last);
        logic [16:0] r;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        r = op ? {1'b0, m_acc} + {1'b0, d} : {1'b0, m_acc} - {1'b0, d};
        m_acc = r[15:0];
        m_ovf = m_ovf | r[16];
        m_cnt++;
        if (last) begin
            sb.push_back('{m_acc, m_ovf, m_cnt});
            m_acc = '0;
            m_ovf = 1'b0;
            m_cnt = 0;
        end
    endtask

    task automatic collect(input string name);
        exp_t e;
        int   w;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: out_valid=%b required 1", name, out_valid);
        end
        w = 0;
        while (out_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: empty queue", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (out_acc !== e.acc) begin errors++; $display("FAIL %s acc: got %h required %h", name, out_acc, e.acc); end
            checks++;
            if (out_ovf !== e.ovf) begin errors++; $display("FAIL %s ovf: got %b required %b", name, out_ovf, e.ovf); end
            checks++;
            if (int'(out_count) != sat(e.cnt, 255)) begin errors++; $display("FAIL %s count: got %0d required %0d", name, out_count, sat(e.cnt, 255)); end
            checks++;
            if (int'(s_out_count) != sat(e.cnt, 3)) begin errors++; $display("FAIL %s count_w2: got %0d required %0d", name, s_out_count, sat(e.cnt, 3)); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL %s after_handshake: ready/valid=%b%b required 10", name, in_ready, out_valid); end
        checks++;
        if ({out_acc, out_ovf, out_count} !== 25'd0) begin errors++; $display("FAIL %s cleared: acc=%h ovf=%b count=%0d required 0", name, out_acc, out_ovf, out_count); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_op = 1'b1; in_last = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        checks++;
        if ({out_acc, out_ovf, out_count, out_valid} !== 26'd0) begin errors++; $display("FAIL reset_state: acc=%h ovf=%b count=%0d valid=%b required 0", out_acc, out_ovf, out_count, out_valid); end
        #10 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_basic;
        send(16'h0003, 1'b1, 1'b0);
        send(16'h0004, 1'b1, 1'b0);
        send(16'h0005, 1'b1, 1'b1);
        collect("basic");
    endtask

    task automatic test_wrap;
        send(16'hFFFF, 1'b1, 1'b0);
        send(16'h0002, 1'b1, 1'b1);
        collect("wrap");
    endtask

    task automatic test_sub_single;
        send(16'h0001, 1'b0, 1'b1);
        collect("sub_single");
    endtask

    task automatic test_sticky;
        send(16'h8000, 1'b1, 1'b0);
        send(16'h8000, 1'b1, 1'b0);
        send(16'h0001, 1'b1, 1'b1);
        collect("sticky");
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 5; i++) send(16'h0001, 1'b1, i == 4);
        collect("saturate");
    endtask

    task automatic test_hold_clear;
        exp_t e;
        send(16'h0010, 1'b1, 1'b1);
        e = sb.pop_front();
        in_valid = 1'b1; in_data = 16'h1234; in_op = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid} !== 2'b01) begin errors++; $display("FAIL hold_ready cycle %0d: ready/valid=%b%b required 01", i, in_ready, out_valid); end
            checks++;
            if (out_acc !== e.acc || int'(out_count) != e.cnt) begin errors++; $display("FAIL hold_stable cycle %0d: acc=%h count=%0d required %h %0d", i, out_acc, out_count, e.acc, e.cnt); end
        end
        clear = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, out_acc, out_count} !== 26'h1_0000 << 8) begin errors++; $display("FAIL hold_clear: valid=%b ready=%b acc=%h count=%0d required 0 1 0 0", out_valid, in_ready, out_acc, out_count); end
        in_valid = 1'b1; in_data = 16'h0005; clear = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; clear = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_acc, out_count} !== 25'h1_0000 << 8) begin errors++; $display("FAIL clear_over_accept: ready=%b acc=%h count=%0d required 1 0 0", in_ready, out_acc, out_count); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        send(16'h0001, 1'b1, 1'b0);
        send(16'h0002, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_acc !== sb[0].acc) begin errors++; $display("FAIL b2b_first: valid=%b acc=%h required 1 %h", out_valid, out_acc, sb[0].acc); end
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        send(16'h0007, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_acc !== sb[0].acc || int'(out_count) != sb[0].cnt) begin errors++; $display("FAIL b2b_second: valid=%b acc=%h count=%0d required 1 %h %0d", out_valid, out_acc, out_count, sb[0].acc, sb[0].cnt); end
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_acc !== 16'h0) begin errors++; $display("FAIL b2b_end: ready=%b acc=%h required 1 0", in_ready, out_acc); end
    endtask

    task automatic test_async_reset;
        send(16'h0005, 1'b1, 1'b0);
        send(16'h0006, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_acc, out_count, s_out_count} !== 26'd0) begin errors++; $display("FAIL async_reset: acc=%h count=%0d count_w2=%0d required 0", out_acc, out_count, s_out_count); end
        m_acc = '0; m_ovf = 1'b0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_release: ready=%b valid=%b required 1 0", in_ready, out_valid); end
        send(16'h0009, 1'b1, 1'b1);
        collect("after_reset");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_sub_single;
        test_sticky;
        test_saturate;
        test_hold_clear;
        test_back_to_back;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
